// File: rtl/box_line_gen.sv
// Horizontal run generator: captures a run descriptor on start and streams one
// pixel per accepted handshake (solid / dashed / outline / clear), then pulses done.
module box_line_gen #(
  parameter int XW = 12,
  parameter int CW = 4,
  parameter int DW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [XW-1:0] i_x0,
  input  logic [XW-1:0] i_width,
  input  logic [1:0]    i_mode,
  input  logic [DW-1:0] i_dash_len,
  input  logic [CW-1:0] i_fg_color,
  input  logic [CW-1:0] i_bg_color,
  output logic          o_busy,
  output logic          o_pix_valid,
  input  logic          i_pix_ready,
  output logic [XW-1:0] o_pix_x,
  output logic [XW-1:0] o_pix_delta,
  output logic [CW-1:0] o_pix_color,
  output logic          o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] M_SOLID = 2'd0;
  localparam logic [1:0] M_DASH  = 2'd1;
  localparam logic [1:0] M_OUTL  = 2'd2;
  localparam logic [1:0] M_CLEAR = 2'd3;

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [DW-1:0] D_ONE = DW'(1);

  logic [1:0]    r_state;
  logic [XW-1:0] r_x0;
  logic [XW-1:0] r_width;
  logic [1:0]    r_mode;
  logic [DW-1:0] r_dash_len;
  logic [CW-1:0] r_fg;
  logic [CW-1:0] r_bg;
  logic [DW-1:0] r_seg;
  logic          r_ph;
  logic          r_busy;
  logic          r_pix_valid;
  logic [XW-1:0] r_pix_x;
  logic [XW-1:0] r_pix_delta;
  logic [CW-1:0] r_pix_color;
  logic          r_done;

  logic          w_accept;
  logic          w_last;
  logic [XW-1:0] w_delta_nxt;
  logic          w_seg_wrap;
  logic [DW-1:0] w_seg_nxt;
  logic          w_ph_nxt;
  logic [CW-1:0] w_color_nxt;
  logic [CW-1:0] w_start_color;
  logic [DW-1:0] w_dash_cap;

  assign w_accept    = (r_state == S_RUN) && r_pix_valid && i_pix_ready;
  assign w_last      = (r_pix_delta == r_width - X_ONE);
  assign w_delta_nxt = r_pix_delta + X_ONE;
  assign w_seg_wrap  = (r_seg == r_dash_len - D_ONE);
  assign w_seg_nxt   = w_seg_wrap ? '0 : r_seg + D_ONE;
  assign w_ph_nxt    = r_ph ^ w_seg_wrap;

  // First pixel of any run is fg except in clear mode
  assign w_start_color = (i_mode == M_CLEAR) ? i_bg_color : i_fg_color;
  assign w_dash_cap    = (i_dash_len == '0) ? D_ONE : i_dash_len;

  always_comb begin
    w_color_nxt = r_fg;
    case (r_mode)
      M_SOLID: w_color_nxt = r_fg;
      M_DASH:  w_color_nxt = w_ph_nxt ? r_bg : r_fg;
      M_OUTL:  w_color_nxt = (w_delta_nxt == r_width - X_ONE) ? r_fg : r_bg;
      M_CLEAR: w_color_nxt = r_bg;
      default: w_color_nxt = r_fg;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_width     <= '0;
      r_mode      <= '0;
      r_dash_len  <= '0;
      r_fg        <= '0;
      r_bg        <= '0;
      r_seg       <= '0;
      r_ph        <= 1'b0;
      r_busy      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_delta <= '0;
      r_pix_color <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // busy still high here means done is on the wire; drop busy, ignore start
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (i_start) begin
            r_x0        <= i_x0;
            r_width     <= i_width;
            r_mode      <= i_mode;
            r_dash_len  <= w_dash_cap;
            r_fg        <= i_fg_color;
            r_bg        <= i_bg_color;
            r_seg       <= '0;
            r_ph        <= 1'b0;
            r_busy      <= 1'b1;
            r_pix_x     <= i_x0;
            r_pix_delta <= '0;
            if (i_width != '0) begin
              r_pix_valid <= 1'b1;
              r_pix_color <= w_start_color;
              r_state     <= S_RUN;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last) begin
              r_pix_valid <= 1'b0;
              r_state     <= S_FIN;
            end else begin
              r_pix_delta <= w_delta_nxt;
              r_pix_x     <= r_x0 + w_delta_nxt;
              r_pix_color <= w_color_nxt;
              r_seg       <= w_seg_nxt;
              r_ph        <= w_ph_nxt;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_x     = r_pix_x;
  assign o_pix_delta = r_pix_delta;
  assign o_pix_color = r_pix_color;
  assign o_done      = r_done;

endmodule

// File: tb/tb_box_line_gen.sv
// Scoreboard bench for box_line_gen: directed runs push expected pixels,
// a negedge monitor pops and compares on every accepted handshake.
module tb_box_line_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] x0;
  logic [11:0] width;
  logic [1:0]  mode;
  logic [3:0]  dash_len;
  logic [3:0]  fg_color;
  logic [3:0]  bg_color;
  logic        busy;
  logic        pix_valid;
  logic        pix_ready;
  logic [11:0] pix_x;
  logic [11:0] pix_delta;
  logic [3:0]  pix_color;
  logic        done;

  box_line_gen #(.XW(12), .CW(4), .DW(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_x0(x0), .i_width(width),
    .i_mode(mode), .i_dash_len(dash_len), .i_fg_color(fg_color), .i_bg_color(bg_color),
    .o_busy(busy), .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix_x(pix_x),
    .o_pix_delta(pix_delta), .o_pix_color(pix_color), .o_done(done)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] d;
    logic [3:0]  c;
  } pix_t;

  pix_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  int   accept_count = 0;
  bit   rdy_toggle = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready driver: constant 1 or toggling every cycle
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) pix_ready = ~pix_ready;
      else pix_ready = 1'b1;
    end
  end

  // Monitor: pixel scoreboard, stall stability, done latency, busy drop
  initial begin
    int   cyc = 0;
    int   last_acc = 0;
    bit   has_acc = 0;
    bit   prev_stall = 0;
    bit   prev_done = 0;
    pix_t held;
    pix_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (prev_stall) begin
          chk("stall_valid", 32'(pix_valid), 32'd1);
          chk("stall_hold", 32'({pix_x, pix_delta, pix_color}), 32'(held));
        end
        if (prev_done) begin
          chk("busy_after_done", 32'({busy, done}), 32'd0);
        end
        if (pix_valid && pix_ready) begin
          accept_count++;
          last_acc = cyc;
          has_acc = 1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel: got x=%h d=%0d c=%h expected none", pix_x, pix_delta, pix_color);
          end else begin
            e = sb.pop_front();
            $display("pix x=%h d=%0d c=%h", pix_x, pix_delta, pix_color);
            chk("pix_x", 32'(pix_x), 32'(e.x));
            chk("pix_delta", 32'(pix_delta), 32'(e.d));
            chk("pix_color", 32'(pix_color), 32'(e.c));
          end
        end
        if (done) begin
          done_count++;
          $display("done at cycle %0d", cyc);
          if (has_acc) chk("done_latency", 32'(cyc - last_acc), 32'd2);
          has_acc = 0;
        end
        prev_stall = pix_valid && !pix_ready;
        held = '{x: pix_x, d: pix_delta, c: pix_color};
        prev_done = done;
      end else begin
        prev_stall = 0;
        prev_done = 0;
        has_acc = 0;
      end
    end
  end

  task automatic push_run(input logic [11:0] px0, input int n, input logic [39:0] cols);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{x: px0 + 12'(i), d: 12'(i), c: cols[4*i +: 4]});
    end
  endtask

  task automatic launch(input logic [11:0] px0, input logic [11:0] w, input logic [1:0] m,
                        input logic [3:0] dl, input logic [3:0] fg, input logic [3:0] bg);
    @(posedge clk);
    #1;
    x0 = px0; width = w; mode = m; dash_len = dl; fg_color = fg; bg_color = bg;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid", 32'(pix_valid), 32'(w != 0));
    if (w != 0) chk("start_delta", 32'(pix_delta), 32'd0);
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (done_count == base && t < 400) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (done_count == base) begin
      failures++;
      $display("FAIL done_timeout: got no done expected one within 400 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_count), 32'(base + 1));
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; x0 = '0; width = '0; mode = '0;
    dash_len = '0; fg_color = '0; bg_color = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, pix_valid, pix_x, pix_delta, pix_color, done}), 32'd0);
    reset = 1'b0;

    // Solid, no backpressure
    base = done_count;
    push_run(12'd100, 5, 40'hAAAAA);
    launch(12'd100, 12'd5, 2'b00, 4'd0, 4'hA, 4'h0);
    wait_done(base);

    // Dashed with toggling ready
    rdy_toggle = 1;
    base = done_count;
    push_run(12'd0, 10, 40'h2111222111);
    launch(12'd0, 12'd10, 2'b01, 4'd3, 4'd1, 4'd2);
    wait_done(base);
    rdy_toggle = 0;

    // Outline edge widths
    base = done_count;
    push_run(12'd20, 4, 40'h7007);
    launch(12'd20, 12'd4, 2'b10, 4'd0, 4'd7, 4'd0);
    wait_done(base);
    base = done_count;
    push_run(12'd30, 1, 40'h7);
    launch(12'd30, 12'd1, 2'b10, 4'd0, 4'd7, 4'd0);
    wait_done(base);
    base = done_count;
    launch(12'd40, 12'd0, 2'b10, 4'd0, 4'd7, 4'd0);
    @(posedge clk);
    #1;
    chk("w0_done", 32'({done, pix_valid}), 32'b10);
    wait_done(base);

    // Wrap with a start mid-run that must be ignored
    rdy_toggle = 1;
    base = done_count;
    push_run(12'hFFE, 4, 40'h3333);
    launch(12'hFFE, 12'd4, 2'b11, 4'd0, 4'd5, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    x0 = 12'h123; width = 12'd2; mode = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(base);
    rdy_toggle = 0;

    // Reset mid-run after 3 accepts
    base = accept_count;
    push_run(12'd50, 8, 40'h66666666);
    launch(12'd50, 12'd8, 2'b00, 4'd0, 4'd6, 4'd0);
    while (accept_count < base + 3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_outputs", 32'({busy, pix_valid, pix_x, pix_delta, pix_color, done}), 32'd0);
    chk("abort_accepts", 32'(accept_count - base), 32'd3);
    sb.delete();
    base = done_count;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", 32'(done_count), 32'(base));
    push_run(12'd5, 2, 40'h11);
    launch(12'd5, 12'd2, 2'b00, 4'd0, 4'd1, 4'd0);
    wait_done(base);

    // dash_len 0 behaves as 1
    base = done_count;
    push_run(12'd60, 4, 40'h9595);
    launch(12'd60, 12'd4, 2'b01, 4'd0, 4'd5, 4'd9);
    wait_done(base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
